// File: rtl/pmod_frame_arbiter.sv
// Round-robin frame arbiter that serializes one 256-bit frame at a time onto an 8-bit PMOD port.
// Optional CRC-8 trailer byte is enabled by defining PMOD_ARB_CRC_EN.
module pmod_frame_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_SRC*256-1:0]   s_data,
  input  logic [NUM_SRC-1:0]       s_valid,
  output logic [NUM_SRC-1:0]       s_ready,
  output logic [7:0]               pmod_output,
  output logic                     pmod_strobe,
  output logic                     busy,
  output logic [3:0]               grant_id
);

  localparam logic [7:0]         GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam logic [4:0]         SRC_N    = 5'(NUM_SRC);
  localparam logic [3:0]         SRC_LAST = 4'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
`ifdef PMOD_ARB_CRC_EN
    CRC,
`endif
    GAP
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           rr_ptr;
  logic [3:0]           win_id;
  logic                 win_found;
  logic [2*NUM_SRC-1:0] valid_rot;
  logic [4:0]           win_sum;
  logic [255:0]         frame_q;
  logic [255:0]         frame_sel;
  logic [4:0]           byte_cnt;
  logic [4:0]           nxt_idx;
  logic [7:0]           gap_cnt;
  logic [7:0]           out_d;
  logic                 strobe_d;
  logic                 take;

  // Rotate requests so the search always starts at bit 0, then map the offset back to a source index.
  always_comb begin
    valid_rot = {s_valid, s_valid} >> rr_ptr;
    win_found = 1'b0;
    win_sum   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!win_found && valid_rot[i]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_ptr} + 5'(i);
      end
    end
    win_id = (win_sum >= SRC_N) ? 4'(win_sum - SRC_N) : win_sum[3:0];
  end

  always_comb begin
    frame_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (win_id == 4'(i)) frame_sel = s_data[256*i +: 256];
    end
  end

  assign take = (state == IDLE) && win_found && !areset;

`ifdef PMOD_ARB_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_nxt;

  always_comb begin
    crc_nxt = crc_q ^ frame_q[{~byte_cnt, 3'b000} +: 8];
    for (int unsigned b = 0; b < 8; b++) begin
      crc_nxt = crc_nxt[7] ? ({crc_nxt[6:0], 1'b0} ^ 8'h07) : {crc_nxt[6:0], 1'b0};
    end
  end
`endif

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (win_found) state_nxt = HEADER;
      HEADER: state_nxt = DATA;
      DATA: begin
        if (byte_cnt == 5'd31) begin
`ifdef PMOD_ARB_CRC_EN
          state_nxt = CRC;
`else
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
        end
      end
`ifdef PMOD_ARB_CRC_EN
      CRC:    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
      GAP:    if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output byte is decoded from the next state so the registered port lines up with the state it belongs to.
  always_comb begin
    busy     = (state != IDLE) && !areset;
    s_ready  = take ? (ONE_HOT0 << win_id) : '0;
    nxt_idx  = (state == HEADER) ? 5'd0 : byte_cnt + 5'd1;
    out_d    = '0;
    strobe_d = 1'b0;
    case (state_nxt)
      HEADER: begin
        out_d    = {4'hA, win_id};
        strobe_d = 1'b1;
      end
      DATA: begin
        out_d    = frame_q[{~nxt_idx, 3'b000} +: 8];
        strobe_d = 1'b1;
      end
`ifdef PMOD_ARB_CRC_EN
      CRC: begin
        out_d    = crc_nxt;
        strobe_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      frame_q     <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      pmod_output <= '0;
      pmod_strobe <= 1'b0;
`ifdef PMOD_ARB_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      pmod_output <= out_d;
      pmod_strobe <= strobe_d;
      byte_cnt    <= (state == DATA) ? byte_cnt + 5'd1 : '0;
      gap_cnt     <= (state == GAP) ? gap_cnt + 8'd1 : '0;
`ifdef PMOD_ARB_CRC_EN
      crc_q       <= (state == DATA) ? crc_nxt : '0;
`endif
      if (take) begin
        frame_q  <= frame_sel;
        grant_id <= win_id;
        rr_ptr   <= (win_id == SRC_LAST) ? '0 : win_id + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pmod_frame_arbiter.sv
// Randomized bench for pmod_frame_arbiter against a frame-queue reference model.
// Honours PMOD_ARB_CRC_EN to expect the CRC trailer byte.
module tb_pmod_frame_arbiter;

  localparam int unsigned NS  = 4;
  localparam int unsigned GAP = 4;
  localparam int unsigned NZ  = 2;
`ifdef PMOD_ARB_CRC_EN
  localparam int unsigned FRAME_LEN = 34;
`else
  localparam int unsigned FRAME_LEN = 33;
`endif

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                areset;
  logic [NS*256-1:0]   s_data;
  logic [NS-1:0]       s_valid;
  logic [NS-1:0]       s_ready;
  logic [7:0]          pmod_output;
  logic                pmod_strobe;
  logic                busy;
  logic [3:0]          grant_id;

  logic                z_areset;
  logic [NZ*256-1:0]   z_data;
  logic [NZ-1:0]       z_valid;
  logic [NZ-1:0]       z_ready;
  logic [7:0]          z_out;
  logic                z_strobe;
  logic                z_busy;
  logic [3:0]          z_grant;

  pmod_frame_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(GAP)) dut (
    .aclk(aclk), .areset(areset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pmod_output(pmod_output), .pmod_strobe(pmod_strobe), .busy(busy), .grant_id(grant_id)
  );

  pmod_frame_arbiter #(.NUM_SRC(NZ), .GAP_CYCLES(0)) dut_z (
    .aclk(aclk), .areset(z_areset), .s_data(z_data), .s_valid(z_valid), .s_ready(z_ready),
    .pmod_output(z_out), .pmod_strobe(z_strobe), .busy(z_busy), .grant_id(z_grant)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  exp_q[$];
  int unsigned rr = 0;
  logic [3:0]  exp_grant = '0;
  bit          cur_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

`ifdef PMOD_ARB_CRC_EN
  function automatic logic [7:0] crc8_ref(input logic [255:0] f);
    logic [7:0] c;
    c = 8'h00;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c ^ f[255-8*i -: 8];
      for (int unsigned b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  function automatic logic [NS*256-1:0] rand_data();
    logic [NS*256-1:0] r;
    for (int unsigned w = 0; w < NS*8; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  // One clock: drive inputs, check s_ready, let the edge happen, then check the registered outputs.
  task automatic run_cycle(input logic rst, input logic [NS-1:0] v, input logic [NS*256-1:0] d);
    logic [NS-1:0] exp_ready;
    bit            granted;
    int unsigned   win;
    int unsigned   k;
    logic [8:0]    e;
    logic [255:0]  f;
    @(negedge aclk);
    areset  = rst;
    s_valid = v;
    s_data  = d;
    #1;
    exp_ready = '0;
    granted   = 1'b0;
    win       = 0;
    if (!rst && !cur_busy) begin
      for (int unsigned i = 0; i < NS; i++) begin
        k = (rr + i) % NS;
        if (!granted && v[k]) begin
          granted = 1'b1;
          win     = k;
        end
      end
      if (granted) exp_ready[win] = 1'b1;
    end
    check("s_ready", 32'(s_ready), 32'(exp_ready));
    if (rst) check("busy_in_reset", 32'(busy), 32'd0);
    @(posedge aclk);
    #1;
    if (rst) begin
      exp_q.delete();
      rr        = 0;
      exp_grant = '0;
    end else if (granted) begin
      f = d[256*win +: 256];
      exp_q.push_back({1'b1, 4'hA, 4'(win)});
      for (int unsigned i = 0; i < 32; i++) exp_q.push_back({1'b1, f[255-8*i -: 8]});
`ifdef PMOD_ARB_CRC_EN
      exp_q.push_back({1'b1, crc8_ref(f)});
`endif
      for (int unsigned g = 0; g < GAP; g++) exp_q.push_back(9'h000);
      rr        = (win + 1) % NS;
      exp_grant = 4'(win);
    end
    if (exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      cur_busy = 1'b1;
    end else begin
      e        = 9'h000;
      cur_busy = 1'b0;
    end
    check("pmod_output", 32'(pmod_output), 32'(e[7:0]));
    check("pmod_strobe", 32'(pmod_strobe), 32'(e[8]));
    check("busy", 32'(busy), 32'(cur_busy));
    check("grant_id", 32'(grant_id), 32'(exp_grant));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NS*256-1:0] d;
    logic [NS-1:0]     v;
    logic              rst;
    int                guard;
    int                hi;
    int                lo;

    areset   = 1'b1;
    s_valid  = '0;
    s_data   = '0;
    z_areset = 1'b1;
    z_valid  = '0;
    z_data   = '0;

    repeat (3) run_cycle(1'b1, '0, '0);

    // Incrementing-byte frame from source 0.
    d = '0;
    for (int unsigned i = 0; i < 32; i++) d[255-8*i -: 8] = 8'(i + 1);
    run_cycle(1'b0, 4'b0001, d);
    repeat (40) run_cycle(1'b0, '0, rand_data());

    // All-zero frame must still be sent.
    run_cycle(1'b0, 4'b1000, '0);
    repeat (40) run_cycle(1'b0, '0, '0);

    repeat (4*(1 + FRAME_LEN + GAP) + 2) run_cycle(1'b0, '1, rand_data());
    repeat (45) run_cycle(1'b0, '0, rand_data());

    // Source 2 requests while source 1 is on the wire.
    run_cycle(1'b0, 4'b0010, rand_data());
    repeat (80) run_cycle(1'b0, 4'b0110, rand_data());
    repeat (45) run_cycle(1'b0, '0, rand_data());

    // Reset while data byte 10 is on the port.
    run_cycle(1'b0, 4'b0100, rand_data());
    repeat (11) run_cycle(1'b0, '0, rand_data());
    run_cycle(1'b1, '0, rand_data());
    run_cycle(1'b0, 4'b0001, rand_data());
    repeat (40) run_cycle(1'b0, '0, rand_data());

    if (FRAME_LEN == 34) begin
      d = '1;
      run_cycle(1'b0, 4'b0001, d);
      repeat (40) run_cycle(1'b0, '0, rand_data());
    end

    repeat (1500) begin
      for (int unsigned k = 0; k < NS; k++) v[k] = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      run_cycle(rst, v, rand_data());
    end
    run_cycle(1'b0, '0, '0);

    // Zero-gap instance with both sources always requesting.
    @(negedge aclk);
    for (int unsigned w = 0; w < NZ*8; w++) z_data[32*w +: 32] = $urandom();
    z_valid  = '1;
    z_areset = 1'b0;
    guard = 0;
    @(posedge aclk);
    #1;
    while (!z_strobe && guard < 10) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    check("z_first_strobe", 32'(guard < 10), 32'd1);
    for (int unsigned f = 0; f < 3; f++) begin
      check("z_header", 32'(z_out), 32'({4'hA, 4'(f % 2)}));
      hi = 0;
      while (z_strobe && hi < 100) begin
        hi++;
        @(posedge aclk);
        #1;
      end
      check("z_frame_len", 32'(hi), 32'(FRAME_LEN));
      lo = 0;
      while (!z_strobe && lo < 100) begin
        lo++;
        @(posedge aclk);
        #1;
      end
      check("z_gap_len", 32'(lo), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pmod_frame_arbiter.md
PMOD_FRAME_ARBITER -- requirements
Module: pmod_frame_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of frame requesters, legal range 2..16.
REQ-002 Parameter GAP_CYCLES, default 4: idle cycles after each frame, legal range 0..255.
REQ-003 aclk  input  1  single clock; all logic rising-edge.
REQ-004 areset  input  1  synchronous reset, active-high.
REQ-005 s_data  input  NUM_SRC*256  frame per source; source k occupies bits [256k+255:256k].
REQ-006 s_valid  input  NUM_SRC  source k has a frame pending.
REQ-007 s_ready  output  NUM_SRC  frame accept; transfer occurs when s_valid[k] & s_ready[k].
REQ-008 pmod_output  output  8  serialized byte to PMOD pins, registered.
REQ-009 pmod_strobe  output  1  high when pmod_output carries a header, data or CRC byte.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 grant_id  output  4  index of the source whose frame is in flight; holds the last value in IDLE.

Function
REQ-012 FSM states: IDLE, HEADER, DATA, CRC (macro only), GAP.
REQ-013 In IDLE, s_ready is combinational: one-hot on the round-robin winner among asserted s_valid; all zero if none valid; always zero outside IDLE.
REQ-014 Round-robin search starts at pointer rr_ptr and proceeds upward, wrapping modulo NUM_SRC; on a transfer, rr_ptr <= winner+1 mod NUM_SRC.
REQ-015 Transfer at cycle T: s_data slice is latched, grant_id <= winner, FSM -> HEADER; header byte visible on pmod_output at T+1.
REQ-016 HEADER lasts 1 cycle: pmod_output = {4'hA, grant_id}, strobe=1.
REQ-017 DATA lasts exactly 32 cycles: byte i (i=0..31) = latched bits [255-8i:248-8i], MSB byte first, strobe=1.
REQ-018 An all-zero frame is transmitted normally; data value never suppresses transmission.
REQ-019 GAP lasts GAP_CYCLES cycles with pmod_output=0, strobe=0, then IDLE; GAP_CYCLES=0 skips GAP and returns directly to IDLE.
REQ-020 s_valid changes while busy are ignored; a deasserted s_valid before grant is never selected; s_data need only be stable in the transfer cycle.
REQ-021 Back-to-back: with GAP_CYCLES=0 and a pending request, the next transfer occurs in the first IDLE cycle, so the frame-to-frame gap is exactly one IDLE cycle (strobe=0).
REQ-022 Byte counter is 5 bits and wraps from 31 only by leaving DATA; no other counter exceeds its range.

Reset
REQ-023 While areset is high: FSM=IDLE, rr_ptr=0, grant_id=0, pmod_output=0, pmod_strobe=0, busy=0, s_ready=0, latched frame cleared.
REQ-024 Reset asserted mid-frame aborts the frame immediately; the next cycle after release starts in IDLE with no residual bytes emitted.

Configuration
REQ-025 Macro PMOD_ARB_CRC_EN defined: after DATA, a 1-cycle CRC state emits CRC-8 (poly 0x07, init 0x00, MSB-first, no final XOR) over the 32 data bytes (header excluded), strobe=1, then GAP.
REQ-026 Macro undefined: no CRC state or CRC logic; DATA goes directly to GAP (or IDLE); frame is 33 strobed bytes.

Verification
REQ-027 Single source 0, s_data=256'h0102...1F20, GAP=4 -> cycles T+1..T+33: A0,01,02..20 with strobe=1, then 4 zero cycles, busy falls at T+38 (no CRC).
REQ-028 All four s_valid held high, 4 frames -> grant_id order 0,1,2,3, headers A0,A1,A2,A3; rr_ptr wraps to 0.
REQ-029 Source 2 asserts during source 1's frame -> s_ready[2]=0 until IDLE, then granted with header A2.
REQ-030 areset pulsed at data byte 10 -> next cycle pmod_output=0, strobe=0, busy=0; after release a new frame starts with a full header.
REQ-031 PMOD_ARB_CRC_EN, all-zero frame -> 33 strobed bytes A0,00..00 then CRC byte 00; frame of 32x8'hFF -> CRC byte matches the CRC-8/0x07 reference model.
REQ-032 GAP_CYCLES=0, two sources always valid -> exactly one strobe-low cycle between consecutive frames.
